// File: rtl/motor_phase_seq.sv
// Four-phase ZF/SP drive sequencer with programmable on/dead time, step count
// and direction. All outputs are registered; ENB freezes the sequence in place.
module motor_phase_seq #(
  parameter int ON_W   = 25,
  parameter int DEAD_W = 25,
  parameter int STEP_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENB,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic [ON_W-1:0]   on_time,
  input  logic [DEAD_W-1:0] dead_time,
  output logic              ZF,
  output logic              SP,
  output logic              EN,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [ON_W-1:0]     cnt_q, cnt_d;
  logic [DEAD_W-1:0]   dcnt_q, dcnt_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                cont_q, cont_d;
  logic                dir_q, dir_d;
  logic [ON_W-1:0]     on_ld_q, on_ld_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                zf_q, zf_d, sp_q, sp_d, en_q, en_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [1:0]          phase_nx;
  logic [ON_W-1:0]     on_eff_m1;

  function automatic logic [1:0] phase_bits(input logic [1:0] p);
    logic [1:0] zs;
    case (p)
      2'd0:    zs = 2'b11;
      2'd1:    zs = 2'b10;
      2'd2:    zs = 2'b01;
      default: zs = 2'b00;
    endcase
    return zs;
  endfunction

  // Counters hold "cycles left minus one", so on_time==0 loads the same as 1.
  assign on_eff_m1 = (on_time == '0) ? '0 : on_time - ON_W'(1);
  assign phase_nx  = dir_q ? phase_q - 2'd1 : phase_q + 2'd1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    dir_d   = dir_q;
    on_ld_d = on_ld_q;
    dead_d  = dead_q;
    zf_d    = zf_q;
    sp_d    = sp_q;
    en_d    = en_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (start && !stop && !ENB) begin
          state_d      = DRIVE;
          dir_d        = dir;
          cont_d       = (steps == '0);
          rem_d        = steps;
          on_ld_d      = on_eff_m1;
          dead_d       = dead_time;
          cnt_d        = on_eff_m1;
          {zf_d, sp_d} = phase_bits(phase_q);
          en_d         = 1'b1;
        end
      end
      DRIVE: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (ENB) begin
          en_d = 1'b0;
        end else begin
          en_d = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ON_W'(1);
          end else begin
            phase_d = phase_nx;
            if (!cont_q) rem_d = rem_q - STEP_W'(1);
            if (!cont_q && rem_q == STEP_W'(1)) begin
              state_d = IDLE;
              en_d    = 1'b0;
              done_d  = 1'b1;
            end else if (dead_q != '0) begin
              state_d = DEAD;
              dcnt_d  = dead_q - DEAD_W'(1);
              en_d    = 1'b0;
            end else begin
              cnt_d        = on_ld_q;
              {zf_d, sp_d} = phase_bits(phase_nx);
            end
          end
        end
      end
      DEAD: begin
        en_d = 1'b0;
        if (stop) begin
          state_d = IDLE;
        end else if (!ENB) begin
          if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - DEAD_W'(1);
          end else begin
            state_d      = DRIVE;
            cnt_d        = on_ld_q;
            {zf_d, sp_d} = phase_bits(phase_q);
            en_d         = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      dir_q   <= 1'b0;
      on_ld_q <= '0;
      dead_q  <= '0;
      zf_q    <= 1'b0;
      sp_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      dir_q   <= dir_d;
      on_ld_q <= on_ld_d;
      dead_q  <= dead_d;
      zf_q    <= zf_d;
      sp_q    <= sp_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ZF        = zf_q;
  assign SP        = sp_q;
  assign EN        = en_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: doc/motor_phase_seq.md
Name: motor_phase_seq

Overview:
Parametrised successor to the smart-car drive-phase sequencer. It steps a motor driver through four ZF/SP drive phases in a selectable direction. On-time and dead-time are programmable at run time, and it supports a fixed step count or continuous running. Sits between the car control FSM and the H-bridge pins. The control FSM issues start/stop; the driver consumes ZF, SP and EN.

Parameters:
ON_W, 25, width of on_time input and drive counter
DEAD_W, 25, width of dead_time input and dead counter
STEP_W, 16, width of steps input and remaining-step counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
ENB  in  1  inhibit; 1 = force EN low and freeze sequencer
start  in  1  one-cycle start request, honoured only in IDLE
stop  in  1  one-cycle abort request
dir  in  1  0 = forward P0->P1->P2->P3->P0; 1 = reverse P0->P3->P2->P1->P0
steps  in  STEP_W  drive phases to run; 0 = continuous
on_time  in  ON_W  drive-phase length in cycles; 0 treated as 1
dead_time  in  DEAD_W  dead-gap length in cycles; 0 = no gap
ZF  out  1  driver direction bit
SP  out  1  driver phase bit
EN  out  1  driver enable
phase  out  2  index of current/next drive phase
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse on step-count completion

Behaviour:
- Reset (RST_N=0, async): state=IDLE, ZF=0, SP=0, EN=0, phase=0, busy=0, done=0, all counters 0. All outputs are registered.
- Phase table: P0 ZF=1 SP=1; P1 ZF=1 SP=0; P2 ZF=0 SP=1; P3 ZF=0 SP=0.
- States:
  - IDLE: EN=0.
  - DRIVE: EN=1, ZF/SP from the phase table for phase.
  - DEAD: EN=0, ZF/SP hold last values.
- IDLE->DRIVE: start=1, stop=0 and ENB=0 in cycle k. In that cycle, dir, steps, on_time and dead_time are latched. EN=1 from cycle k+1.
- The first drive phase after start is the current phase value, which persists across runs so the rotor position is kept. After reset, the first forward run is P0,P1,P2,P3.
- DRIVE lasts max(on_time,1) cycles. At the end of a DRIVE:
  - phase advances per dir, wrapping modulo 4.
  - If steps!=0, remaining is decremented. If remaining reaches 0, go to IDLE with done=1 for 1 cycle and EN=0 in that same cycle; no dead gap follows.
  - Otherwise go to DEAD if dead_time!=0, else straight to the next DRIVE with no EN gap.
- DEAD lasts dead_time cycles, then goes to DRIVE.
- stop=1 in any non-IDLE state: next cycle state=IDLE, EN=0, busy=0, done=0. phase keeps its already-advanced value; a partial drive does not advance it.
- start and stop in the same cycle: stop wins; remain or return to IDLE.
- ENB=1:
  - EN=0 next cycle; state, counters and ZF/SP are frozen.
  - On ENB fall, the sequencer resumes with the remaining cycle count of the interrupted phase, and EN returns 1 the next cycle if in DRIVE.
  - start is ignored while ENB=1; stop is still honoured.
- Inputs other than start/stop are ignored while busy, and are re-latched only at the next start.
- Counters use ON_W/DEAD_W-bit unsigned compare; no overflow is possible since each counter runs to at most its latched value.

Test Plan:
1. Reset, then start with dir=0 steps=4 on_time=4 dead_time=2. Required: EN high for 4 cycles, low for 2, repeated. ZF/SP sequence 11,10,01,00. done pulses once with EN low in the same cycle, and no trailing dead gap. Final phase=0.
2. Reverse run from phase=0 with dir=1 steps=3 on_time=3 dead_time=0. Required: ZF/SP sequence 11,00,01 with EN continuously high for 9 cycles, then phase=1 and done=1.
3. Continuous run with steps=0 on_time=5 dead_time=1, then stop asserted in the 3rd cycle of the second drive. Required: EN=0 and busy=0 the next cycle, done never asserts, phase=1.
4. ENB raised for 7 cycles in the 2nd cycle of a drive with on_time=6. Required: EN=0 throughout the freeze with ZF/SP held, then after release EN=1 for exactly 4 more cycles.
5. start and stop asserted together in IDLE. Required: busy stays 0. Then start alone with on_time=0, steps=1. Required: EN high for exactly 1 cycle, then done=1.
6. RST_N pulled low mid-DRIVE. Required: all outputs 0 immediately, and phase=0.
